dcache_controller: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache between the CPU byte-access port and the 256x8 block memory (4-byte blocks, 6-bit block address, busywait handshake).
- Holds tag/valid/dirty/data arrays and runs the miss FSM that sequences block write-back and fetch on the memory port.
- Stalls the CPU through busywait until the access hits.

---
 rtl/dcache_controller.sv | 172 +++++++++++++++++
 tb/tb_dcache_controller.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate byte cache in front of a 64 x 32-bit block memory.
// Build option: define DCACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module dcache_controller #(
    parameter int INDEX_BITS = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [7:0]  address,
    input  logic [7:0]  writedata,
    output logic [7:0]  readdata,
    output logic        busywait,
    output logic        mem_read,
    output logic        mem_write,
    output logic [5:0]  mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_busywait,
    output logic [1:0]  dbg_state
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 6 - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        ALLOCATE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [LINES-1:0]   r_valid;
    logic [LINES-1:0]   r_dirty;
    logic [TAG_W-1:0]   r_tag  [LINES];
    logic [31:0]        r_data [LINES];
    logic [31:0]        r_fill;

    logic [TAG_W-1:0]      w_tag;
    logic [INDEX_BITS-1:0] w_index;
    logic [1:0]            w_offset;
    logic                  w_access;
    logic                  w_hit;
    logic                  w_idle_hit;
    logic                  w_next_mem_read;
    logic                  w_next_mem_write;
    logic [5:0]            w_next_mem_address;
    logic [31:0]           w_next_mem_writedata;

    assign w_tag      = address[7:2+INDEX_BITS];
    assign w_index    = address[1+INDEX_BITS:2];
    assign w_offset   = address[1:0];
    assign w_access   = read ^ write;
    assign w_hit      = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_idle_hit = (r_state == IDLE) && w_hit;

    // The stall depends only on registered cache state, never on mem_busywait.
    assign busywait  = w_access && !w_idle_hit && !reset;
    assign readdata  = r_data[w_index][{w_offset, 3'b000} +: 8];
    assign dbg_state = r_state;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_access && !w_hit) begin
                    w_next_state = r_dirty[w_index] ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                if (!mem_busywait) begin
                    w_next_state = FETCH;
                end
            end
            FETCH: begin
                if (!mem_busywait) begin
                    w_next_state = ALLOCATE;
                end
            end
            ALLOCATE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Memory request registers are loaded with what the next state asks for.
    always_comb begin
        w_next_mem_read      = 1'b0;
        w_next_mem_write     = 1'b0;
        w_next_mem_address   = 6'd0;
        w_next_mem_writedata = 32'd0;
        if (w_next_state == WRITEBACK) begin
            w_next_mem_write     = 1'b1;
            w_next_mem_address   = {r_tag[w_index], w_index};
            w_next_mem_writedata = r_data[w_index];
        end else if (w_next_state == FETCH) begin
            w_next_mem_read    = 1'b1;
            w_next_mem_address = {w_tag, w_index};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= 6'd0;
            mem_writedata <= 32'd0;
            r_fill        <= 32'd0;
        end else begin
            r_state       <= w_next_state;
            mem_read      <= w_next_mem_read;
            mem_write     <= w_next_mem_write;
            mem_address   <= w_next_mem_address;
            mem_writedata <= w_next_mem_writedata;
            if ((r_state == FETCH) && !mem_busywait) begin
                r_fill <= mem_readdata;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_dirty <= '0;
            for (int i = 0; i < LINES; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else if (r_state == ALLOCATE) begin
            r_data[w_index]  <= r_fill;
            r_tag[w_index]   <= w_tag;
            r_valid[w_index] <= 1'b1;
            r_dirty[w_index] <= 1'b0;
        end else if (write && !read && w_idle_hit) begin
            r_data[w_index][{w_offset, 3'b000} +: 8] <= writedata;
            r_dirty[w_index]                         <= 1'b1;
        end
    end

`ifdef DCACHE_STATS_EN
    logic r_after_alloc;

    // The hit that completes a miss right after ALLOCATE is not a real hit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_after_alloc <= 1'b0;
            hit_count     <= 16'd0;
            miss_count    <= 16'd0;
        end else begin
            r_after_alloc <= (r_state == ALLOCATE);
            if (w_access && w_idle_hit && !r_after_alloc && (hit_count != 16'hFFFF)) begin
                hit_count <= hit_count + 16'd1;
            end
            if ((r_state == IDLE) && (w_next_state != IDLE) && (miss_count != 16'hFFFF)) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed-vector bench for dcache_controller with a latency-modelled block memory
// and a negedge monitor that checks read data, stall length and memory requests.
module tb_dcache_controller;

    localparam int MEM_LAT = 3;

    logic        clock;
    logic        reset;
    logic        read;
    logic        write;
    logic [7:0]  address;
    logic [7:0]  writedata;
    logic [7:0]  readdata;
    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;
    logic [1:0]  dbg_state;

    dcache_controller #(.INDEX_BITS(3)) dut (
        .clock         (clock),
        .reset         (reset),
        .read          (read),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .busywait      (busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait),
        .dbg_state     (dbg_state)
    );

    // Clock and reset-driven memory model.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    bit [7:0]   mem [256];
    bit [255:0] mem_wr_valid;
    int         mem_cnt;

    function automatic logic [7:0] init_byte(input logic [7:0] a);
        case (a)
            8'h25:   return 8'h5C;
            8'h30:   return 8'h3C;
            8'h11:   return 8'h1A;
            8'h45:   return 8'h77;
            8'hFC:   return 8'hE4;
            8'hFF:   return 8'hE1;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] mem_byte(input logic [7:0] a);
        return mem_wr_valid[a] ? mem[a] : init_byte(a);
    endfunction

    always_comb begin
        mem_readdata = {mem_byte({mem_address, 2'd3}), mem_byte({mem_address, 2'd2}),
                        mem_byte({mem_address, 2'd1}), mem_byte({mem_address, 2'd0})};
    end

    assign mem_busywait = (mem_read || mem_write) && (mem_cnt != MEM_LAT);

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_cnt <= 0;
        end else if (mem_read || mem_write) begin
            if (mem_cnt == MEM_LAT) begin
                mem_cnt <= 0;
                if (mem_write) begin
                    for (int b = 0; b < 4; b++) begin
                        mem[{mem_address, 2'(b)}]          <= mem_writedata[b*8 +: 8];
                        mem_wr_valid[{mem_address, 2'(b)}] <= 1'b1;
                    end
                end
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end else begin
            mem_cnt <= 0;
        end
    end

    // Scoreboard state: expected read bytes, stall lengths and memory requests.
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_stall_q[$];
    logic [38:0] exp_mem_q[$];

    int   n_vec;
    int   n_err;
    int   n_timeouts;
    int   timeouts_seen;
    int   stall_cnt;
    logic prev_rd;
    logic prev_wr;
    logic end_check;
    logic end_done;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: all comparisons happen here, on the falling edge.
    initial begin
        n_vec = 0;
        n_err = 0;
        timeouts_seen = 0;
        stall_cnt = 0;
        prev_rd = 1'b0;
        prev_wr = 1'b0;
        end_done = 1'b0;
    end

    always @(negedge clock) begin
        if (n_timeouts != timeouts_seen) begin
            cmp("access timeout count", 64'(n_timeouts), 64'(timeouts_seen));
            timeouts_seen = n_timeouts;
        end
        if (reset) begin
            cmp("reset outputs", {busywait, mem_read, mem_write, mem_address, mem_writedata, readdata}, 64'd0);
            stall_cnt = 0;
            prev_rd = 1'b0;
            prev_wr = 1'b0;
        end else begin
            if (read ^ write) begin
                if (busywait) begin
                    stall_cnt++;
                end else begin
                    if (exp_stall_q.size() == 0) begin
                        cmp("unexpected access completion", 64'd1, 64'd0);
                    end else begin
                        cmp("stall cycles", 64'(stall_cnt), 64'(exp_stall_q.pop_front()));
                    end
                    if (read) begin
                        if (exp_q.size() == 0) begin
                            cmp("unexpected read completion", 64'd1, 64'd0);
                        end else begin
                            cmp("readdata", 64'(readdata), 64'(exp_q.pop_front()));
                        end
                    end
                    stall_cnt = 0;
                end
            end
            if (read && write) begin
                cmp("illegal access outputs", {busywait, mem_read, mem_write}, 64'd0);
            end
            if (mem_read && mem_write) begin
                cmp("mem_read and mem_write both high", 64'd1, 64'd0);
            end
            if ((mem_read && !prev_rd) || (mem_write && !prev_wr)) begin
                if (exp_mem_q.size() == 0) begin
                    cmp("unexpected memory request", {mem_write, mem_address, mem_writedata}, 64'd0);
                end else begin
                    cmp("memory request", {mem_write, mem_address, mem_write ? mem_writedata : 32'd0},
                        64'(exp_mem_q.pop_front()));
                end
            end
            prev_rd = mem_read;
            prev_wr = mem_write;
        end
        if (end_check && !end_done) begin
            cmp("pending read expectations", 64'(exp_q.size()), 64'd0);
            cmp("pending stall expectations", 64'(exp_stall_q.size()), 64'd0);
            cmp("pending memory expectations", 64'(exp_mem_q.size()), 64'd0);
            end_done = 1'b1;
        end
    end

    // Driver tasks.
    task automatic exp_rd(input logic [7:0] b);
        exp_q.push_back(b);
    endtask

    task automatic exp_stall(input int n);
        exp_stall_q.push_back(8'(n));
    endtask

    task automatic exp_mem(input logic w, input logic [5:0] a, input logic [31:0] d);
        exp_mem_q.push_back({w, a, d});
    endtask

    task automatic start_acc(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        read      = r;
        write     = w;
        address   = a;
        writedata = d;
    endtask

    task automatic wait_done();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (!busywait) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            $display("FAIL access timeout: busywait still 1 at address 0x%0h, expected 0 within 100 cycles", address);
            n_timeouts++;
        end
        @(posedge clock);
        #1;
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] b, input int stalls);
        exp_rd(b);
        exp_stall(stalls);
        start_acc(1'b1, 1'b0, a, 8'h00);
        wait_done();
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int stalls);
        exp_stall(stalls);
        start_acc(1'b0, 1'b1, a, d);
        wait_done();
    endtask

    initial begin
        n_timeouts = 0;
        end_check  = 1'b0;
        reset      = 1'b1;
        start_acc(1'b1, 1'b0, 8'h05, 8'h00);

        // Reset with read held, then a cold miss on 0x05: fetch block 1.
        exp_mem(1'b0, 6'h01, 32'h0);
        exp_rd(8'h00);
        exp_stall(MEM_LAT + 3);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        wait_done();

        // Write hit marks the line dirty without memory traffic; read it back.
        do_write(8'h05, 8'hAB, 0);
        do_read(8'h05, 8'hAB, 0);

        // Conflict on dirty index 1: write back block 1, fetch block 9.
        exp_mem(1'b1, 6'h01, 32'h0000AB00);
        exp_mem(1'b0, 6'h09, 32'h0);
        do_read(8'h25, 8'h5C, 2 * (MEM_LAT + 1) + 2);

        // Clean miss back to 0x05 returns the written-back byte from memory.
        exp_mem(1'b0, 6'h01, 32'h0);
        do_read(8'h05, 8'hAB, MEM_LAT + 3);

        // Write-allocate miss, then neighbours, then a dirty eviction of index 4.
        exp_mem(1'b0, 6'h0C, 32'h0);
        do_write(8'h31, 8'h99, MEM_LAT + 3);
        do_read(8'h31, 8'h99, 0);
        do_read(8'h30, 8'h3C, 0);
        exp_mem(1'b1, 6'h0C, 32'h0000993C);
        exp_mem(1'b0, 6'h04, 32'h0);
        do_read(8'h11, 8'h1A, 2 * (MEM_LAT + 1) + 2);

        // Highest tag/index and both end offsets.
        exp_mem(1'b0, 6'h3F, 32'h0);
        do_read(8'hFF, 8'hE1, MEM_LAT + 3);
        do_read(8'hFC, 8'hE4, 0);

        // Reset in the middle of a fetch; the held read then refetches from scratch.
        exp_mem(1'b0, 6'h11, 32'h0);
        start_acc(1'b1, 1'b0, 8'h45, 8'h00);
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        repeat (2) @(posedge clock);
        exp_mem(1'b0, 6'h11, 32'h0);
        exp_rd(8'h77);
        exp_stall(MEM_LAT + 3);
        #1 reset = 1'b0;
        wait_done();

        // Cache is empty again; reinstall 0x05, then an illegal read+write leaves it intact.
        exp_mem(1'b0, 6'h01, 32'h0);
        do_read(8'h05, 8'hAB, MEM_LAT + 3);
        start_acc(1'b1, 1'b1, 8'h05, 8'hFF);
        repeat (3) @(posedge clock);
        #1 start_acc(1'b0, 1'b0, 8'h05, 8'h00);
        do_read(8'h05, 8'hAB, 0);

        repeat (3) @(negedge clock);
        @(posedge clock);
        end_check = 1'b1;
        @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
